turn_scheduler: RTL and testbench
=================================

Name: turn_scheduler

Overview:
Parametrised turn controller for the board-game core. It holds the current player index and advances it on a pulse from the game FSM, with these additions over the earlier fixed next-turn logic:
- runtime player count
- eliminated-player skip mask
- direction reversal
- round counting
- explicit start/stop
It sits between the main game-state FSM (which issues advance/reverse pulses) and the display/scoring logic (which consumes cur_player and turn_start).

Parameters:
MAX_PLAYERS, 4, maximum supported players (2..16).
ROUND_W, 8, width of round counter.
PW (localparam), $clog2(MAX_PLAYERS), player index width.

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: load config, begin game
stop  in  1  pulse: end game, return to IDLE
num_players  in  PW+1  active player count, sampled on start
first_player  in  PW  starting index, sampled on start
advance  in  1  pulse: pass turn to next eligible player
reverse  in  1  pulse: toggle play direction
skip_mask  in  MAX_PLAYERS  bit i=1 means player i is eliminated; read live during search
cur_player  out  PW  index of player holding the turn
turn_valid  out  1  1 in ACTIVE state only
turn_start  out  1  one-cycle pulse when a new turn is granted
dir  out  1  0=ascending, 1=descending
round_cnt  out  ROUND_W  completed wraps of the turn pointer, saturating
all_skipped  out  1  1 in HALT state (no eligible player)
cfg_err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, cur_player=0, dir=0, round_cnt=0, and turn_valid, turn_start, all_skipped, cfg_err all 0. Internal latched N=0.
- States: IDLE, SEARCH, ACTIVE, HALT.
- Priority when inputs coincide: start > stop > reverse > advance.
- start, from any state:
  - If num_players==0 or num_players>MAX_PLAYERS: pulse cfg_err next cycle, state unchanged.
  - Otherwise: latch N=num_players, dir=0, round_cnt=0, candidate=(first_player<N ? first_player : 0), go to SEARCH.
- stop, from any non-IDLE state: go to IDLE next cycle. turn_valid and all_skipped drop; cur_player holds its value.
- reverse: toggles dir in SEARCH, ACTIVE or HALT; ignored in IDLE. If reverse and advance arrive in the same cycle, the new direction is used for that advance.
- SEARCH examines one candidate per cycle:
  - If skip_mask[candidate]==0: cur_player<=candidate, go to ACTIVE, turn_start=1 for exactly that transition cycle.
  - Otherwise step the candidate: ascending is (c==N-1 ? 0 : c+1); descending is (c==0 ? N-1 : c-1).
  - After N consecutive rejected candidates, go to HALT, all_skipped=1.
  - Latency from advance to turn_start is 1+k cycles, where k = number of skipped candidates (worst case N).
- ACTIVE, on advance: candidate=step(cur_player), go to SEARCH. turn_valid=0 during SEARCH.
- Only the first candidate is examined on SEARCH entry after start. A step never examines the initial candidate.
- advance is ignored in IDLE, SEARCH and HALT.
- HALT, on advance: retry the search from step(cur_player); this allows recovery after skip_mask clears.
- round_cnt increments by 1 on every step that wraps: N-1 to 0 ascending, or 0 to N-1 descending. It saturates at all-ones.
- N==1: step returns the same index, and every step counts as a wrap, so each advance re-grants player 0 and increments round_cnt.
- skip_mask changes take effect on the next examined candidate. Eliminating cur_player in ACTIVE has no effect until the next advance.

Decomposition:
- Shared package turn_pkg:
  - state enum (IDLE, SEARCH, ACTIVE, HALT)
  - DIR_FWD/DIR_REV constants
  - function next_idx(c, N, dir) returning the stepped index and a wrap flag
- Single sub-module: turn_step (combinational next-index/wrap computation), instantiated once. Counters and FSM stay in turn_scheduler.

Test Plan:
- MAX=4, start N=3 first=0, mask=0, three advances -> cur_player 0,1,2,0. Each turn_start comes 1 cycle after advance. round_cnt=1 after the final advance.
- N=4, cur=1, mask=4'b0100, advance -> one skip, cur_player=3, turn_start 2 cycles after advance.
- N=4, cur=2, reverse and advance in the same cycle -> dir=1, cur_player=1. Continued advances go 0, then 3 with round_cnt+1.
- N=3, mask=3'b111, start -> HALT after 3 SEARCH cycles, all_skipped=1. Clear mask to 0 and advance -> ACTIVE, cur_player=1.
- start with num_players=5 (MAX=4) -> cfg_err pulse, state stays IDLE. Start with num_players=2, first_player=3 -> cur_player=0.
- rst_n low during SEARCH -> all outputs immediately at reset values. start and advance asserted together in ACTIVE -> start wins, round_cnt=0, cur_player=first_player.

Source files
------------

// File: rtl/turn_pkg.sv
// Shared types and the turn-pointer step function for the turn scheduler.
package turn_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      ACTIVE = 2'd2,
      HALT   = 2'd3
   } state_t;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   // Wide enough for any index or count up to 16 players.
   localparam int unsigned IDX_W = 5;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             wrap;
   } step_t;

   function automatic step_t next_idx(input logic [IDX_W-1:0] c,
                                      input logic [IDX_W-1:0] n,
                                      input logic             d);
      step_t r;
      r.idx  = c;
      r.wrap = 1'b0;
      if (d == DIR_FWD) begin
         if (c == n - IDX_W'(1)) begin
            r.idx  = '0;
            r.wrap = 1'b1;
         end else begin
            r.idx = c + IDX_W'(1);
         end
      end else begin
         if (c == '0) begin
            r.idx  = n - IDX_W'(1);
            r.wrap = 1'b1;
         end else begin
            r.idx = c - IDX_W'(1);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/turn_scheduler_if.sv
// Game-FSM <-> turn scheduler signal bundle.
interface turn_scheduler_if #(
   parameter int unsigned MAX_PLAYERS = 4,
   parameter int unsigned ROUND_W     = 8
);
   localparam int unsigned PW = $clog2(MAX_PLAYERS);

   logic                   start;
   logic                   stop;
   logic [PW:0]            num_players;
   logic [PW-1:0]          first_player;
   logic                   advance;
   logic                   reverse;
   logic [MAX_PLAYERS-1:0] skip_mask;

   logic [PW-1:0]          cur_player;
   logic                   turn_valid;
   logic                   turn_start;
   logic                   dir;
   logic [ROUND_W-1:0]     round_cnt;
   logic                   all_skipped;
   logic                   cfg_err;

   modport master (
      output start, stop, num_players, first_player, advance, reverse, skip_mask,
      input  cur_player, turn_valid, turn_start, dir, round_cnt, all_skipped, cfg_err
   );

   modport slave (
      input  start, stop, num_players, first_player, advance, reverse, skip_mask,
      output cur_player, turn_valid, turn_start, dir, round_cnt, all_skipped, cfg_err
   );
endinterface

// File: rtl/turn_step.sv
// Combinational next-index and wrap detection for the turn pointer.
module turn_step
   import turn_pkg::*;
#(
   parameter int unsigned MAX_PLAYERS = 4
) (
   input  logic [$clog2(MAX_PLAYERS)-1:0] cur,
   input  logic [$clog2(MAX_PLAYERS):0]   n,
   input  logic                           dir,
   output logic [$clog2(MAX_PLAYERS)-1:0] nxt_c,
   output logic                           wrap_c
);
   localparam int unsigned PW = $clog2(MAX_PLAYERS);

   step_t s;
   logic  unused_idx_hi;

   always_comb s = next_idx(IDX_W'(cur), IDX_W'(n), dir);

   assign nxt_c         = s.idx[PW-1:0];
   assign wrap_c        = s.wrap;
   assign unused_idx_hi = ^s.idx;
endmodule

// File: rtl/turn_scheduler.sv
// Turn controller: runtime player count, skip mask, reversal, round counting.
module turn_scheduler
   import turn_pkg::*;
#(
   parameter int unsigned MAX_PLAYERS = 4,
   parameter int unsigned ROUND_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   turn_scheduler_if.slave  bus
);
   localparam int unsigned PW = $clog2(MAX_PLAYERS);

   state_t             state_q, state_d;
   logic [PW-1:0]      cur_q, cur_d;
   logic [PW-1:0]      cand_q, cand_d;
   logic [PW:0]        n_q, n_d;
   logic [PW:0]        rej_q, rej_d;
   logic               dir_q, dir_d;
   logic [ROUND_W-1:0] round_q, round_d;
   logic               valid_q, valid_d;
   logic               tstart_q, tstart_d;
   logic               halt_q, halt_d;
   logic               err_q, err_d;

   logic [PW-1:0]      step_in;
   logic               step_dir;
   logic [PW-1:0]      step_nxt;
   logic               step_wrap;
   logic               cfg_ok;

   // Searches step the candidate; advances from ACTIVE/HALT step the current holder.
   assign step_in  = (state_q == SEARCH) ? cand_q : cur_q;
   assign step_dir = dir_q ^ (bus.reverse & ~bus.start & ~bus.stop & (state_q != IDLE));
   assign cfg_ok   = (bus.num_players != '0) && (bus.num_players <= (PW+1)'(MAX_PLAYERS));

   turn_step #(.MAX_PLAYERS(MAX_PLAYERS)) u_step (
      .cur    (step_in),
      .n      (n_q),
      .dir    (step_dir),
      .nxt_c  (step_nxt),
      .wrap_c (step_wrap)
   );

   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      cand_d   = cand_q;
      n_d      = n_q;
      rej_d    = rej_q;
      dir_d    = dir_q;
      round_d  = round_q;
      tstart_d = 1'b0;
      err_d    = 1'b0;

      if (bus.start) begin
         if (!cfg_ok) begin
            err_d = 1'b1;
         end else begin
            n_d     = bus.num_players;
            dir_d   = DIR_FWD;
            round_d = '0;
            rej_d   = '0;
            cand_d  = ((PW+1)'(bus.first_player) < bus.num_players) ? bus.first_player : '0;
            state_d = SEARCH;
         end
      end else if (bus.stop) begin
         state_d = IDLE;
      end else if (state_q != IDLE) begin
         dir_d = step_dir;
         case (state_q)
            SEARCH: begin
               if (!bus.skip_mask[cand_q]) begin
                  cur_d    = cand_q;
                  tstart_d = 1'b1;
                  state_d  = ACTIVE;
               end else if (rej_q == n_q - (PW+1)'(1)) begin
                  state_d = HALT;
               end else begin
                  rej_d  = rej_q + (PW+1)'(1);
                  cand_d = step_nxt;
                  if (step_wrap && (round_q != '1)) round_d = round_q + ROUND_W'(1);
               end
            end
            ACTIVE, HALT: begin
               if (bus.advance) begin
                  rej_d   = '0;
                  cand_d  = step_nxt;
                  state_d = SEARCH;
                  if (step_wrap && (round_q != '1)) round_d = round_q + ROUND_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      valid_d = (state_d == ACTIVE);
      halt_d  = (state_d == HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cur_q    <= '0;
         cand_q   <= '0;
         n_q      <= '0;
         rej_q    <= '0;
         dir_q    <= DIR_FWD;
         round_q  <= '0;
         valid_q  <= 1'b0;
         tstart_q <= 1'b0;
         halt_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         cand_q   <= cand_d;
         n_q      <= n_d;
         rej_q    <= rej_d;
         dir_q    <= dir_d;
         round_q  <= round_d;
         valid_q  <= valid_d;
         tstart_q <= tstart_d;
         halt_q   <= halt_d;
         err_q    <= err_d;
      end
   end

   assign bus.cur_player  = cur_q;
   assign bus.turn_valid  = valid_q;
   assign bus.turn_start  = tstart_q;
   assign bus.dir         = dir_q;
   assign bus.round_cnt   = round_q;
   assign bus.all_skipped = halt_q;
   assign bus.cfg_err     = err_q;
endmodule

// File: tb/tb_turn_scheduler.sv
// Directed scoreboard bench for turn_scheduler (MAX_PLAYERS=4, ROUND_W=8).
module tb_turn_scheduler;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   typedef struct {
      int unsigned cur;
      int unsigned rnd;
      int unsigned d;
      int unsigned lat;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   turn_scheduler_if #(.MAX_PLAYERS(4), .ROUND_W(8)) bus ();
   turn_scheduler #(.MAX_PLAYERS(4), .ROUND_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int unsigned cur, input int unsigned rnd,
                       input int unsigned d, input int unsigned lat);
      exp_t e;
      e.cur = cur; e.rnd = rnd; e.d = d; e.lat = lat;
      sb.push_back(e);
   endtask

   // Counts edges after the triggering edge until turn_start, then scores the grant.
   task automatic wait_grant(input string tag);
      exp_t e;
      int   n;
      e = sb.pop_front();
      n = 0;
      while (!bus.turn_start && n < 40) begin
         tick();
         n++;
      end
      if (!bus.turn_start) begin
         check({tag, "_timeout"}, 0, 1);
      end else begin
         check({tag, "_lat"}, n, e.lat);
         check({tag, "_cur"}, bus.cur_player, e.cur);
         check({tag, "_rnd"}, bus.round_cnt, e.rnd);
         check({tag, "_dir"}, bus.dir, e.d);
         check({tag, "_valid"}, bus.turn_valid, 1);
      end
   endtask

   task automatic do_start(input int unsigned n, input int unsigned f, input logic adv);
      bus.start        = 1'b1;
      bus.num_players  = 3'(n);
      bus.first_player = 2'(f);
      bus.advance      = adv;
      tick();
      bus.start   = 1'b0;
      bus.advance = 1'b0;
   endtask

   task automatic adv(input string tag, input logic rev, input int unsigned lat,
                      input int unsigned cur, input int unsigned rnd, input int unsigned d);
      push(cur, rnd, d, lat);
      bus.advance = 1'b1;
      bus.reverse = rev;
      tick();
      bus.advance = 1'b0;
      bus.reverse = 1'b0;
      wait_grant(tag);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_cur"}, bus.cur_player, 0);
      check({tag, "_valid"}, bus.turn_valid, 0);
      check({tag, "_tstart"}, bus.turn_start, 0);
      check({tag, "_dir"}, bus.dir, 0);
      check({tag, "_rnd"}, bus.round_cnt, 0);
      check({tag, "_halt"}, bus.all_skipped, 0);
      check({tag, "_err"}, bus.cfg_err, 0);
   endtask

   initial begin
      bus.start = 1'b0; bus.stop = 1'b0; bus.advance = 1'b0; bus.reverse = 1'b0;
      bus.num_players = '0; bus.first_player = '0; bus.skip_mask = '0;
      #12;
      check_reset("rst");
      rst_n = 1'b1;
      tick();

      // N=3 rotation with wrap
      push(0, 0, 0, 1);
      do_start(3, 0, 1'b0);
      wait_grant("n3_start");
      adv("n3_a1", 1'b0, 1, 1, 0, 0);
      adv("n3_a2", 1'b0, 1, 2, 0, 0);
      adv("n3_a3", 1'b0, 1, 0, 1, 0);

      // single skipped player
      push(1, 0, 0, 1);
      do_start(4, 1, 1'b0);
      wait_grant("skip_start");
      bus.skip_mask = 4'b0100;
      adv("skip_a", 1'b0, 2, 3, 0, 0);

      // reverse with advance in the same cycle
      bus.skip_mask = '0;
      push(2, 0, 0, 1);
      do_start(4, 2, 1'b0);
      wait_grant("rev_start");
      adv("rev_a1", 1'b1, 1, 1, 0, 1);
      adv("rev_a2", 1'b0, 1, 0, 0, 1);
      adv("rev_a3", 1'b0, 1, 3, 1, 1);

      // all eliminated -> HALT, then recovery
      push(0, 0, 0, 1);
      do_start(4, 0, 1'b0);
      wait_grant("halt_pre");
      bus.skip_mask = 4'b0111;
      do_start(3, 0, 1'b0);
      tick();
      tick();
      check("halt_early", bus.all_skipped, 0);
      tick();
      check("halt_set", bus.all_skipped, 1);
      check("halt_valid", bus.turn_valid, 0);
      bus.skip_mask = '0;
      adv("halt_rec", 1'b0, 1, 1, 0, 0);
      check("halt_clr", bus.all_skipped, 0);

      // stop, bad config, clamped first_player
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      check("stop_valid", bus.turn_valid, 0);
      check("stop_cur", bus.cur_player, 1);
      do_start(5, 0, 1'b0);
      check("cfg_err", bus.cfg_err, 1);
      check("cfg_valid", bus.turn_valid, 0);
      tick();
      check("cfg_err_pulse", bus.cfg_err, 0);
      check("cfg_idle", bus.turn_valid, 0);
      push(0, 0, 0, 1);
      do_start(2, 3, 1'b0);
      wait_grant("clamp");

      // start beats advance in ACTIVE
      adv("pre_sa1", 1'b0, 1, 1, 0, 0);
      adv("pre_sa2", 1'b0, 1, 0, 1, 0);
      push(2, 0, 0, 1);
      do_start(4, 2, 1'b1);
      wait_grant("start_adv");

      // single player: every advance wraps
      push(0, 0, 0, 1);
      do_start(1, 0, 1'b0);
      wait_grant("n1_start");
      adv("n1_a1", 1'b0, 1, 0, 1, 0);
      adv("n1_a2", 1'b0, 1, 0, 2, 0);

      // async reset during SEARCH
      bus.skip_mask = 4'b1111;
      do_start(4, 2, 1'b0);
      tick();
      rst_n = 1'b0;
      #1;
      check_reset("rst_search");
      check("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
